// File: rtl/pipelined_prim_chain_if.sv
// Handshake bundle for pipelined_prim_chain: upstream word channel and downstream word channel.
// The slave modport is the chain itself; the master modport is whatever drives and drains it.
interface pipelined_prim_chain_if #(
    parameter int IO_PAIRS = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [IO_PAIRS*2-1:0] in;
    logic                  out_valid;
    logic                  out_ready;
    logic [IO_PAIRS*2-1:0] out;

    modport master (
        output in_valid,
        output in,
        input  in_ready,
        input  out_valid,
        input  out,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in,
        output in_ready,
        output out_valid,
        output out,
        input  out_ready
    );
endinterface

// File: rtl/pipelined_prim_chain.sv
// DEPTH-stage valid/ready register chain applying a 2-bit primitive per pair on entry to each stage.
// Define PRIM_CHAIN_COUNT_EN to add the 16-bit output transfer counter port xfer_count.
module pipelined_prim_chain #(
    parameter int IO_PAIRS = 2,
    parameter int DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef PRIM_CHAIN_COUNT_EN
    output logic [15:0] xfer_count,
`endif
    pipelined_prim_chain_if.slave bus
);
    localparam int W = IO_PAIRS * 2;

    // Per pair: high bit picks up the low bit, low bit inverts (a 2-bit increment, period 4).
    function automatic logic [W-1:0] prim(input logic [W-1:0] x);
        logic [W-1:0] y;
        y = '0;
        for (int j = 0; j < IO_PAIRS; j++) begin
            y[2*j+1] = x[2*j+1] ^ x[2*j];
            y[2*j]   = ~x[2*j];
        end
        return y;
    endfunction

    logic [W-1:0]     stage_data [DEPTH];
    logic [DEPTH-1:0] stage_valid;
    logic [DEPTH-1:0] stage_ready;

    // Bubble-collapsing ready: a stage accepts if it is empty or the stage after it accepts.
    always_comb begin
        logic r;
        r           = bus.out_ready;
        stage_ready = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            r              = ~stage_valid[i] | r;
            stage_ready[i] = r;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [W-1:0] up_data;
            logic         up_valid;
            logic [W-1:0] data_q;
            logic [W-1:0] data_d;
            logic         valid_q;
            logic         valid_d;

            if (gi == 0) begin : g_head
                assign up_data  = bus.in;
                assign up_valid = bus.in_valid;
            end else begin : g_body
                assign up_data  = stage_data[gi-1];
                assign up_valid = stage_valid[gi-1];
            end

            always_comb begin
                data_d  = data_q;
                valid_d = valid_q;
                if (stage_ready[gi]) begin
                    valid_d = up_valid;
                    if (up_valid) begin
                        data_d = prim(up_data);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    data_q  <= data_d;
                    valid_q <= valid_d;
                end
            end

            assign stage_data[gi]  = data_q;
            assign stage_valid[gi] = valid_q;
        end
    endgenerate

    assign bus.in_ready  = stage_ready[0];
    assign bus.out_valid = stage_valid[DEPTH-1];
    assign bus.out       = stage_data[DEPTH-1];

`ifdef PRIM_CHAIN_COUNT_EN
    logic [15:0] xfer_count_q;
    logic [15:0] xfer_count_d;

    // Free-running wrap at 16 bits is intentional.
    always_comb begin
        xfer_count_d = xfer_count_q;
        if (stage_valid[DEPTH-1] && bus.out_ready) begin
            xfer_count_d = xfer_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_count_q <= 16'd0;
        end else begin
            xfer_count_q <= xfer_count_d;
        end
    end

    assign xfer_count = xfer_count_q;
`endif
endmodule

// File: tb/tb_pipelined_prim_chain.sv
// Self-checking bench: three chains (DEPTH 4, 1, 3) share one stimulus stream and are
// checked against a queue model in which each pass through a stage adds 1 (mod 4) to every pair.
module tb_pipelined_prim_chain;
    localparam int PAIRS = 2;
    localparam int W     = PAIRS * 2;
    localparam int NDUT  = 3;

    logic         clk;
    logic         rst;
    logic         tb_in_valid;
    logic [W-1:0] tb_in;
    logic         tb_out_ready;

    int checks;
    int failures;

    pipelined_prim_chain_if #(.IO_PAIRS(PAIRS)) if_a ();
    pipelined_prim_chain_if #(.IO_PAIRS(PAIRS)) if_b ();
    pipelined_prim_chain_if #(.IO_PAIRS(PAIRS)) if_c ();

`ifdef PRIM_CHAIN_COUNT_EN
    logic [15:0] cnt_a, cnt_b, cnt_c;
    logic [15:0] obs_cnt [NDUT];
    assign obs_cnt[0] = cnt_a;
    assign obs_cnt[1] = cnt_b;
    assign obs_cnt[2] = cnt_c;
`endif

    pipelined_prim_chain #(.IO_PAIRS(PAIRS), .DEPTH(4)) dut_a (
        .clk(clk),
        .rst(rst),
`ifdef PRIM_CHAIN_COUNT_EN
        .xfer_count(cnt_a),
`endif
        .bus(if_a)
    );

    pipelined_prim_chain #(.IO_PAIRS(PAIRS), .DEPTH(1)) dut_b (
        .clk(clk),
        .rst(rst),
`ifdef PRIM_CHAIN_COUNT_EN
        .xfer_count(cnt_b),
`endif
        .bus(if_b)
    );

    pipelined_prim_chain #(.IO_PAIRS(PAIRS), .DEPTH(3)) dut_c (
        .clk(clk),
        .rst(rst),
`ifdef PRIM_CHAIN_COUNT_EN
        .xfer_count(cnt_c),
`endif
        .bus(if_c)
    );

    assign if_a.in_valid  = tb_in_valid;
    assign if_a.in        = tb_in;
    assign if_a.out_ready = tb_out_ready;
    assign if_b.in_valid  = tb_in_valid;
    assign if_b.in        = tb_in;
    assign if_b.out_ready = tb_out_ready;
    assign if_c.in_valid  = tb_in_valid;
    assign if_c.in        = tb_in;
    assign if_c.out_ready = tb_out_ready;

    logic         obs_in_ready  [NDUT];
    logic         obs_out_valid [NDUT];
    logic [W-1:0] obs_out       [NDUT];
    assign obs_in_ready[0]  = if_a.in_ready;
    assign obs_in_ready[1]  = if_b.in_ready;
    assign obs_in_ready[2]  = if_c.in_ready;
    assign obs_out_valid[0] = if_a.out_valid;
    assign obs_out_valid[1] = if_b.out_valid;
    assign obs_out_valid[2] = if_c.out_valid;
    assign obs_out[0]       = if_a.out;
    assign obs_out[1]       = if_b.out;
    assign obs_out[2]       = if_c.out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dep(input int k);
        case (k)
            0:       return 4;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    // One stage maps each pair 00->01->10->11->00, so d stages add d mod 4 to every pair.
    function automatic logic [W-1:0] model_out(input logic [W-1:0] x, input int d);
        logic [W-1:0] y;
        logic [1:0]   step;
        y    = '0;
        step = 2'(d % 4);
        for (int p = 0; p < PAIRS; p++) begin
            y[2*p +: 2] = x[2*p +: 2] + step;
        end
        return y;
    endfunction

    // Scoreboard: expected outputs per chain, in acceptance order.
    logic [W-1:0] sb_mem [NDUT][256];
    int           sb_head [NDUT];
    int           sb_tail [NDUT];

    initial begin
        int occ;
        for (int k = 0; k < NDUT; k++) begin
            sb_head[k] = 0;
            sb_tail[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                if (rst) begin
                    sb_head[k] = 0;
                    sb_tail[k] = 0;
                end else begin
                    occ = sb_tail[k] - sb_head[k];
                    checks++;
                    if (obs_in_ready[k] !== !(occ == dep(k) && !tb_out_ready)) begin
                        failures++;
                        if (failures < 40)
                            $display("FAIL sb_in_ready dut%0d occ=%0d: got %b expected %b",
                                     k, occ, obs_in_ready[k], !(occ == dep(k) && !tb_out_ready));
                    end
                    checks++;
                    if (occ == 0 && obs_out_valid[k] !== 1'b0) begin
                        failures++;
                        if (failures < 40)
                            $display("FAIL sb_empty_valid dut%0d: got out_valid=%b expected 0", k, obs_out_valid[k]);
                    end
                    if (occ > 0 && obs_out_valid[k] === 1'b1) begin
                        checks++;
                        if (obs_out[k] !== sb_mem[k][sb_head[k] % 256]) begin
                            failures++;
                            if (failures < 40)
                                $display("FAIL sb_data dut%0d: got %h expected %h",
                                         k, obs_out[k], sb_mem[k][sb_head[k] % 256]);
                        end
                        if (tb_out_ready) sb_head[k]++;
                    end
                    if (tb_in_valid && obs_in_ready[k] === 1'b1) begin
                        sb_mem[k][sb_tail[k] % 256] = model_out(tb_in, dep(k));
                        sb_tail[k]++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        rst         = 1'b1;
        tb_in_valid = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        tb_in_valid  = 1'b0;
        tb_out_ready = 1'b1;
        repeat (12) tick();
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (sb_tail[k] != sb_head[k]) begin
                failures++;
                $display("FAIL drain dut%0d: got %0d words left expected 0", k, sb_tail[k] - sb_head[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        tb_in_valid  = 1'b1;
        tb_in        = 4'h6;
        tb_out_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (obs_out_valid[k] !== 1'b0 || obs_out[k] !== '0) begin
                failures++;
                $display("FAIL reset_out dut%0d: got valid=%b out=%h expected 0/0", k, obs_out_valid[k], obs_out[k]);
            end
            checks++;
            if (obs_in_ready[k] !== 1'b1) begin
                failures++;
                $display("FAIL reset_in_ready dut%0d: got %b expected 1", k, obs_in_ready[k]);
            end
`ifdef PRIM_CHAIN_COUNT_EN
            checks++;
            if (obs_cnt[k] !== 16'd0) begin
                failures++;
                $display("FAIL reset_count dut%0d: got %0d expected 0", k, obs_cnt[k]);
            end
`endif
        end
        tick();
        rst         = 1'b0;
        tb_in_valid = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (obs_out_valid[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_retained dut%0d: got out_valid=%b expected 0", k, obs_out_valid[k]);
            end
        end
        tick();
    endtask

    // Single word into an empty chain: out_valid must rise exactly DEPTH edges after acceptance.
    task automatic test_latency(input logic [W-1:0] val);
        logic exp_v;
        tb_out_ready = 1'b1;
        tb_in        = val;
        tb_in_valid  = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                exp_v = (c == dep(k));
                checks++;
                if (obs_out_valid[k] !== exp_v) begin
                    failures++;
                    $display("FAIL latency_valid dut%0d in=%h c=%0d: got %b expected %b", k, val, c, obs_out_valid[k], exp_v);
                end
                if (exp_v) begin
                    checks++;
                    if (obs_out[k] !== model_out(val, dep(k))) begin
                        failures++;
                        $display("FAIL latency_data dut%0d in=%h: got %h expected %h", k, val, obs_out[k], model_out(val, dep(k)));
                    end
                end
            end
            tick();
            tb_in_valid = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int sent;
        int got;
        bit stall_seen;
        sent       = 0;
        got        = 0;
        stall_seen = 1'b0;
        for (int c = 0; c < 60 && got < 10; c++) begin
            tb_in_valid  = (sent < 10);
            tb_in        = sent[W-1:0];
            tb_out_ready = !(c >= 6 && c <= 9);
            @(negedge clk);
            if (tb_in_valid && obs_in_ready[0] === 1'b0) stall_seen = 1'b1;
            if (obs_out_valid[0] === 1'b1 && tb_out_ready) begin
                checks++;
                if (obs_out[0] !== got[W-1:0]) begin
                    failures++;
                    $display("FAIL bp_order: got %h expected %h", obs_out[0], got[W-1:0]);
                end
                got++;
            end
            if (tb_in_valid && obs_in_ready[0] === 1'b1) sent++;
            tick();
        end
        checks++;
        if (got != 10) begin
            failures++;
            $display("FAIL bp_count: got %0d words expected 10", got);
        end
        checks++;
        if (!stall_seen) begin
            failures++;
            $display("FAIL bp_full: got in_ready never low expected low when full");
        end
        drain();
    endtask

    task automatic test_back_to_back();
        apply_reset(2);
        tb_out_ready = 1'b1;
        tb_in_valid  = 1'b1;
        for (int c = 0; c < 24; c++) begin
            tb_in = W'($urandom);
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (obs_in_ready[k] !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_in_ready dut%0d c=%0d: got %b expected 1", k, c, obs_in_ready[k]);
                end
                checks++;
                if (obs_out_valid[k] !== (c >= dep(k))) begin
                    failures++;
                    $display("FAIL b2b_out_valid dut%0d c=%0d: got %b expected %b", k, c, obs_out_valid[k], (c >= dep(k)));
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            tb_in_valid  = ($urandom_range(0, 3) != 0);
            tb_in        = W'($urandom);
            tb_out_ready = (c % 200 < 150) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
            tick();
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        apply_reset(2);
        tb_out_ready = 1'b0;
        tb_in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tb_in = W'(i + 5);
            tick();
        end
        tb_in_valid = 1'b0;
        rst         = 1'b1;
        tick();
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (obs_out_valid[k] !== 1'b0) begin
                failures++;
                $display("FAIL midreset_valid dut%0d: got %b expected 0", k, obs_out_valid[k]);
            end
        end
        tick();
        rst = 1'b0;
        test_latency(4'h3);
        drain();
    endtask

`ifdef PRIM_CHAIN_COUNT_EN
    task automatic test_counter();
        int n [NDUT];
        apply_reset(2);
        for (int k = 0; k < NDUT; k++) n[k] = 0;
        tb_out_ready = 1'b1;
        tb_in_valid  = 1'b1;
        for (int c = 0; c < 66000 && n[0] < 65537; c++) begin
            tb_in = W'(c);
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                if (obs_out_valid[k] === 1'b1 && tb_out_ready) n[k]++;
            end
            tick();
        end
        tb_in_valid  = 1'b0;
        tb_out_ready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (obs_cnt[k] !== 16'(n[k])) begin
                failures++;
                $display("FAIL count_wrap dut%0d after %0d transfers: got %0d expected %0d", k, n[k], obs_cnt[k], 16'(n[k]));
            end
        end
        checks++;
        if (obs_cnt[0] !== 16'd1) begin
            failures++;
            $display("FAIL count_65537: got %0d expected 1", obs_cnt[0]);
        end
        tick();
        drain();
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        tb_in_valid  = 1'b0;
        tb_in        = '0;
        tb_out_ready = 1'b0;
        tick();
        test_reset();
        test_latency(4'b0000);
        drain();
        test_latency(4'hA);
        drain();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_midflight();
`ifdef PRIM_CHAIN_COUNT_EN
        test_counter();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
